// File: rtl/confreg_sram_resp_pkg.sv
// Shared constants and helpers for the SoC data-side responder:
// register offsets, the default bank select value and a byte-merge function.
package confreg_sram_resp_pkg;

    localparam logic [15:0] CONF_HI_DEF = 16'hBFAF;

    localparam logic [15:0] LED_OFF   = 16'hF000;
    localparam logic [15:0] NUM_OFF   = 16'hF010;
    localparam logic [15:0] SW_OFF    = 16'hF020;
    localparam logic [15:0] TIMER_OFF = 16'hE000;

    typedef enum logic {
        SEL_RAM  = 1'b0,
        SEL_CONF = 1'b1
    } region_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  wen);
        logic [31:0] merged;
        merged = old_w;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) merged[8*i +: 8] = new_w[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/confreg_sram_resp_if.sv
// SRAM-like data port between the core (master) and the responder (slave).
interface confreg_sram_resp_if;
    import confreg_sram_resp_pkg::*;

    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output en, wen, addr, wdata, input rdata);
    modport slave  (input en, wen, addr, wdata, output rdata);

endinterface

// File: rtl/confreg_sram_resp_bram_bw.sv
// Single-port read-first RAM with byte enables; the output register holds
// its value on cycles without an access.
module bram_bw
    import confreg_sram_resp_pkg::*;
#(
    parameter int RAM_AW = 12
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        wen,
    input  logic [RAM_AW-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [2**RAM_AW];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem_q[addr];
            for (int i = 0; i < 4; i++) begin
                if (wen[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/confreg_sram_resp.sv
// Data-side responder: decodes core accesses into the data RAM or the
// configuration register bank (LED, 7-seg number, switches, timer).
module confreg_sram_resp
    import confreg_sram_resp_pkg::*;
#(
    parameter int          RAM_AW  = 12,
    parameter logic [15:0] CONF_HI = CONF_HI_DEF,
    parameter logic [15:0] LED_RST = 16'hFFFF
) (
    input  logic                       clk,
    input  logic                       resetn,
    confreg_sram_resp_if.slave         data_sram,
    input  logic [7:0]                 switch,
    output logic [15:0]                led,
    output logic [31:0]                num_data
);

    logic        conf_hit;
    logic        ram_en;
    logic        reg_wr;
    logic [15:0] off;
    logic [31:0] ram_rdata;

    logic [15:0] led_q, led_d;
    logic [31:0] num_q, num_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0]  sw_meta_q, sw_sync_q;
    logic [31:0] reg_rdata_q, reg_rdata_d;
    region_e     sel_q;

    assign conf_hit = (data_sram.addr[31:16] == CONF_HI);
    assign ram_en   = data_sram.en && !conf_hit;
    assign reg_wr   = data_sram.en && conf_hit && (data_sram.wen != 4'b0000);
    assign off      = data_sram.addr[15:0];

    bram_bw #(.RAM_AW(RAM_AW)) u_bram (
        .clk   (clk),
        .en    (ram_en),
        .wen   (data_sram.wen),
        .addr  (data_sram.addr[RAM_AW+1:2]),
        .wdata (data_sram.wdata),
        .rdata (ram_rdata)
    );

    // Read value is taken from the registers before this cycle's write lands.
    always_comb begin
        reg_rdata_d = 32'h0;
        case (off)
            LED_OFF:   reg_rdata_d = {16'h0, led_q};
            NUM_OFF:   reg_rdata_d = num_q;
            SW_OFF:    reg_rdata_d = {24'h0, sw_sync_q};
            TIMER_OFF: reg_rdata_d = timer_q;
            default:   reg_rdata_d = 32'h0;
        endcase
    end

    always_comb begin
        led_d   = led_q;
        num_d   = num_q;
        timer_d = timer_q + 32'd1;
        if (reg_wr) begin
            case (off)
                LED_OFF: begin
                    led_d[7:0]  = data_sram.wen[0] ? data_sram.wdata[7:0]  : led_q[7:0];
                    led_d[15:8] = data_sram.wen[1] ? data_sram.wdata[15:8] : led_q[15:8];
                end
                NUM_OFF:   num_d   = byte_merge(num_q, data_sram.wdata, data_sram.wen);
                TIMER_OFF: timer_d = byte_merge(timer_q, data_sram.wdata, data_sram.wen);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q       <= LED_RST;
            num_q       <= 32'h0;
            timer_q     <= 32'h0;
            sw_meta_q   <= 8'h0;
            sw_sync_q   <= 8'h0;
            reg_rdata_q <= 32'h0;
            sel_q       <= SEL_CONF;
        end else begin
            led_q     <= led_d;
            num_q     <= num_d;
            timer_q   <= timer_d;
            sw_meta_q <= switch;
            sw_sync_q <= sw_meta_q;
            if (data_sram.en) begin
                sel_q       <= conf_hit ? SEL_CONF : SEL_RAM;
                reg_rdata_q <= reg_rdata_d;
            end
        end
    end

    // Selecting the register path out of reset makes rdata read as zero.
    assign data_sram.rdata = (sel_q == SEL_CONF) ? reg_rdata_q : ram_rdata;
    assign led             = led_q;
    assign num_data        = num_q;

endmodule

// File: tb/tb_confreg_sram_resp.sv
// Directed bench for confreg_sram_resp: a vector table for single-cycle
// accesses plus hand-written timer, switch, hold and reset sequences.
module tb_confreg_sram_resp;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chkRd;
        logic [31:0] expRd;
        logic [15:0] expLed;
        logic [31:0] expNum;
    } vec_t;

    localparam int NVEC = 16;

    logic        clk;
    logic        resetn;
    logic [7:0]  switch;
    logic [15:0] led;
    logic [31:0] num_data;

    int vecCount  = 0;
    int missCount = 0;
    vec_t vecs [NVEC];

    confreg_sram_resp_if bus ();

    confreg_sram_resp dut (
        .clk       (clk),
        .resetn    (resetn),
        .data_sram (bus.slave),
        .switch    (switch),
        .led       (led),
        .num_data  (num_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, actual, expected);
        end
    endtask

    // Drive one access at a falling edge and return at the next falling edge.
    task automatic applyStimulus(input logic en, input logic [3:0] wen,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        bus.en    = en;
        bus.wen   = wen;
        bus.addr  = addr;
        bus.wdata = wdata;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 4'h0, 32'hBFAFF000, 32'h0,        1'b1, 32'h0000FFFF, 16'hFFFF, 32'h0};
        vecs[1]  = '{1'b1, 4'hF, 32'h00000010, 32'h11223344, 1'b0, 32'h0,        16'hFFFF, 32'h0};
        vecs[2]  = '{1'b1, 4'h2, 32'h00000010, 32'hAABBCCDD, 1'b1, 32'h11223344, 16'hFFFF, 32'h0};
        vecs[3]  = '{1'b1, 4'h0, 32'h00000010, 32'h0,        1'b1, 32'h1122CC44, 16'hFFFF, 32'h0};
        vecs[4]  = '{1'b1, 4'hF, 32'hBFAFF010, 32'hDEADBEEF, 1'b1, 32'h0,        16'hFFFF, 32'hDEADBEEF};
        vecs[5]  = '{1'b1, 4'hC, 32'hBFAFF000, 32'h00001234, 1'b1, 32'h0000FFFF, 16'hFFFF, 32'hDEADBEEF};
        vecs[6]  = '{1'b1, 4'h1, 32'hBFAFF000, 32'h000000A0, 1'b1, 32'h0000FFFF, 16'hFFA0, 32'hDEADBEEF};
        vecs[7]  = '{1'b1, 4'h0, 32'hBFAFF000, 32'h0,        1'b1, 32'h0000FFA0, 16'hFFA0, 32'hDEADBEEF};
        vecs[8]  = '{1'b1, 4'hF, 32'hBFAF1234, 32'h12345678, 1'b1, 32'h0,        16'hFFA0, 32'hDEADBEEF};
        vecs[9]  = '{1'b1, 4'h0, 32'hBFAF1234, 32'h0,        1'b1, 32'h0,        16'hFFA0, 32'hDEADBEEF};
        vecs[10] = '{1'b1, 4'h0, 32'hBFAFF010, 32'h0,        1'b1, 32'hDEADBEEF, 16'hFFA0, 32'hDEADBEEF};
        vecs[11] = '{1'b0, 4'hF, 32'h00000010, 32'h0,        1'b1, 32'hDEADBEEF, 16'hFFA0, 32'hDEADBEEF};
        vecs[12] = '{1'b1, 4'h0, 32'h00000010, 32'h0,        1'b1, 32'h1122CC44, 16'hFFA0, 32'hDEADBEEF};
        vecs[13] = '{1'b1, 4'h0, 32'h00004010, 32'h0,        1'b1, 32'h1122CC44, 16'hFFA0, 32'hDEADBEEF};
        vecs[14] = '{1'b1, 4'hF, 32'h00000014, 32'h55667788, 1'b0, 32'h0,        16'hFFA0, 32'hDEADBEEF};
        vecs[15] = '{1'b1, 4'h0, 32'h00000014, 32'h0,        1'b1, 32'h55667788, 16'hFFA0, 32'hDEADBEEF};

        resetn    = 1'b0;
        switch    = 8'h00;
        bus.en    = 1'b0;
        bus.wen   = 4'h0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        repeat (2) @(negedge clk);
        checkOutput("reset rdata", bus.rdata, 32'h0);
        checkOutput("reset led", {16'h0, led}, 32'h0000FFFF);
        checkOutput("reset num", num_data, 32'h0);

        resetn = 1'b1;
        applyStimulus(1'b1, 4'h0, 32'hBFAFE000, 32'h0);
        checkOutput("timer after reset", bus.rdata, 32'h0);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].chkRd) checkOutput($sformatf("vec%0d rdata", i), bus.rdata, vecs[i].expRd);
            checkOutput($sformatf("vec%0d led", i), {16'h0, led}, {16'h0, vecs[i].expLed});
            checkOutput($sformatf("vec%0d num", i), num_data, vecs[i].expNum);
        end

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'hF, 32'hBFAFF010 + 32'(i), 32'hFFFF0000 + 32'(i));
            checkOutput($sformatf("hold%0d rdata", i), bus.rdata, 32'h55667788);
        end
        checkOutput("hold num", num_data, 32'hDEADBEEF);

        // Timer load, wrap, then a single-byte write into a known count.
        applyStimulus(1'b1, 4'hF, 32'hBFAFE000, 32'hFFFFFFFE);
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1'b1, 4'h0, 32'hBFAFE000, 32'h0);
        checkOutput("timer t+1", bus.rdata, 32'hFFFFFFFF);
        applyStimulus(1'b1, 4'h0, 32'hBFAFE000, 32'h0);
        checkOutput("timer wrap", bus.rdata, 32'h00000000);
        applyStimulus(1'b1, 4'h1, 32'hBFAFE000, 32'h12345610);
        checkOutput("timer prewrite", bus.rdata, 32'h00000001);
        applyStimulus(1'b1, 4'h0, 32'hBFAFE000, 32'h0);
        checkOutput("timer bytewrite", bus.rdata, 32'h00000010);

        switch = 8'hA5;
        applyStimulus(1'b1, 4'h0, 32'hBFAFF020, 32'h0);
        checkOutput("switch edge1", bus.rdata, 32'h0);
        applyStimulus(1'b1, 4'h0, 32'hBFAFF020, 32'h0);
        checkOutput("switch edge2", bus.rdata, 32'h0);
        applyStimulus(1'b1, 4'h0, 32'hBFAFF020, 32'h0);
        checkOutput("switch edge3", bus.rdata, 32'h000000A5);
        applyStimulus(1'b1, 4'hF, 32'hBFAFF020, 32'h00000000);
        checkOutput("switch write rd", bus.rdata, 32'h000000A5);
        applyStimulus(1'b1, 4'h0, 32'hBFAFF020, 32'h0);
        checkOutput("switch ro", bus.rdata, 32'h000000A5);

        applyStimulus(1'b1, 4'h0, 32'h00000014, 32'h0);
        checkOutput("preburst rdata", bus.rdata, 32'h55667788);
        bus.addr = 32'h00000010;
        resetn   = 1'b0;
        #1;
        checkOutput("midreset rdata", bus.rdata, 32'h0);
        checkOutput("midreset led", {16'h0, led}, 32'h0000FFFF);
        checkOutput("midreset num", num_data, 32'h0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(1'b1, 4'h0, 32'hBFAFE000, 32'h0);
        checkOutput("timer restart", bus.rdata, 32'h0);
        applyStimulus(1'b1, 4'h0, 32'h00000010, 32'h0);
        checkOutput("ram kept 10", bus.rdata, 32'h1122CC44);
        applyStimulus(1'b1, 4'h0, 32'h00000014, 32'h0);
        checkOutput("ram kept 14", bus.rdata, 32'h55667788);
        applyStimulus(1'b1, 4'h0, 32'hBFAFF000, 32'h0);
        checkOutput("led after reset", bus.rdata, 32'h0000FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
